// File: rtl/mem_stage.sv
// MEM stage of the RV64 pipeline: passes ALU results through and performs
// aligned loads/stores to data memory over a req/ack handshake.
module mem_stage #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_rd,
  output logic            dm_req,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  output logic [7:0]      dm_wstrb,
  input  logic            dm_ack,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            wb_valid,
  output logic            wb_is_load,
  output logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] wb_mem_data,
  output logic [4:0]      wb_rd,
  output logic            wb_err
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LANE_W = 3;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                op_load, op_load_nxt;
  logic [2:0]          op_f3, op_f3_nxt;
  logic [LANE_W-1:0]   op_lane, op_lane_nxt;
  logic [XLEN-1:0]     op_result, op_result_nxt;
  logic [4:0]          op_rd, op_rd_nxt;

  logic                dm_req_nxt, dm_we_nxt;
  logic [XLEN-1:0]     dm_addr_nxt, dm_wdata_nxt;
  logic [7:0]          dm_wstrb_nxt;
  logic                wb_valid_nxt, wb_is_load_nxt, wb_err_nxt;
  logic [XLEN-1:0]     wb_result_nxt, wb_mem_data_nxt;
  logic [4:0]          wb_rd_nxt;

  logic                ex_is_mem;
  logic [LANE_W-1:0]   ex_lane;

  // Funct3 111 has no access size, so it is reported like a misalignment.
  function automatic logic misaligned(input logic [2:0] f3, input logic [LANE_W-1:0] a);
    logic m;
    m = 1'b0;
    if (f3 == 3'b111) begin
      m = 1'b1;
    end else begin
      case (f3[1:0])
        2'b00:   m = 1'b0;
        2'b01:   m = a[0];
        2'b10:   m = (a[1:0] != 2'b00);
        default: m = (a != 3'b000);
      endcase
    end
    return m;
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [2:0]      f3,
                                                  input logic [LANE_W-1:0] lane);
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] r;
    s = rdata >> {lane, 3'b000};
    case (f3)
      3'b000:  r = {{(XLEN-8){s[7]}},   s[7:0]};
      3'b001:  r = {{(XLEN-16){s[15]}}, s[15:0]};
      3'b010:  r = {{(XLEN-32){s[31]}}, s[31:0]};
      3'b011:  r = s;
      3'b100:  r = {{(XLEN-8){1'b0}},   s[7:0]};
      3'b101:  r = {{(XLEN-16){1'b0}},  s[15:0]};
      3'b110:  r = {{(XLEN-32){1'b0}},  s[31:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign ex_ready  = (state == IDLE);
  assign ex_is_mem = ex_is_load | ex_is_store;
  assign ex_lane   = ex_result[LANE_W-1:0];

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    op_load_nxt     = op_load;
    op_f3_nxt       = op_f3;
    op_lane_nxt     = op_lane;
    op_result_nxt   = op_result;
    op_rd_nxt       = op_rd;
    dm_req_nxt      = dm_req;
    dm_we_nxt       = dm_we;
    dm_addr_nxt     = dm_addr;
    dm_wdata_nxt    = dm_wdata;
    dm_wstrb_nxt    = dm_wstrb;
    wb_valid_nxt    = 1'b0;
    wb_is_load_nxt  = wb_is_load;
    wb_result_nxt   = wb_result;
    wb_mem_data_nxt = wb_mem_data;
    wb_rd_nxt       = wb_rd;
    wb_err_nxt      = wb_err;

    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!ex_is_mem) begin
            wb_valid_nxt    = 1'b1;
            wb_is_load_nxt  = 1'b0;
            wb_result_nxt   = ex_result;
            wb_mem_data_nxt = '0;
            wb_rd_nxt       = ex_rd;
            wb_err_nxt      = 1'b0;
          end else if (misaligned(ex_funct3, ex_lane)) begin
            wb_valid_nxt    = 1'b1;
            wb_is_load_nxt  = ex_is_load;
            wb_result_nxt   = ex_result;
            wb_mem_data_nxt = '0;
            wb_rd_nxt       = ex_rd;
            wb_err_nxt      = 1'b1;
          end else begin
            op_load_nxt   = ex_is_load;
            op_f3_nxt     = ex_funct3;
            op_lane_nxt   = ex_lane;
            op_result_nxt = ex_result;
            op_rd_nxt     = ex_rd;
            dm_req_nxt    = 1'b1;
            dm_we_nxt     = ex_is_store;
            dm_addr_nxt   = {ex_result[XLEN-1:LANE_W], {LANE_W{1'b0}}};
            dm_wdata_nxt  = ex_is_store ? (ex_store_data << {ex_lane, 3'b000}) : '0;
            dm_wstrb_nxt  = size_mask(ex_funct3[1:0]) << ex_lane;
            cnt_nxt       = '0;
            state_nxt     = ACCESS;
          end
        end
      end
      ACCESS: begin
        // An ack in the final wait cycle still completes the access normally.
        if (dm_ack) begin
          dm_req_nxt      = 1'b0;
          wb_valid_nxt    = 1'b1;
          wb_is_load_nxt  = op_load;
          wb_result_nxt   = op_result;
          wb_mem_data_nxt = op_load ? load_extend(dm_rdata, op_f3, op_lane) : '0;
          wb_rd_nxt       = op_rd;
          wb_err_nxt      = 1'b0;
          state_nxt       = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          dm_req_nxt      = 1'b0;
          wb_valid_nxt    = 1'b1;
          wb_is_load_nxt  = op_load;
          wb_result_nxt   = op_result;
          wb_mem_data_nxt = '0;
          wb_rd_nxt       = op_rd;
          wb_err_nxt      = 1'b1;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_load     <= 1'b0;
      op_f3       <= '0;
      op_lane     <= '0;
      op_result   <= '0;
      op_rd       <= '0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      dm_wstrb    <= '0;
      wb_valid    <= 1'b0;
      wb_is_load  <= 1'b0;
      wb_result   <= '0;
      wb_mem_data <= '0;
      wb_rd       <= '0;
      wb_err      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      op_load     <= op_load_nxt;
      op_f3       <= op_f3_nxt;
      op_lane     <= op_lane_nxt;
      op_result   <= op_result_nxt;
      op_rd       <= op_rd_nxt;
      dm_req      <= dm_req_nxt;
      dm_we       <= dm_we_nxt;
      dm_addr     <= dm_addr_nxt;
      dm_wdata    <= dm_wdata_nxt;
      dm_wstrb    <= dm_wstrb_nxt;
      wb_valid    <= wb_valid_nxt;
      wb_is_load  <= wb_is_load_nxt;
      wb_result   <= wb_result_nxt;
      wb_mem_data <= wb_mem_data_nxt;
      wb_rd       <= wb_rd_nxt;
      wb_err      <= wb_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver/memory responder queues expected
// WB records, a negedge monitor pops and compares every wb_valid pulse.
module tb_mem_stage;

  localparam int unsigned TIMEOUT = 255;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        dm_req, dm_we, dm_ack;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic [7:0]  dm_wstrb;
  logic        wb_valid, wb_is_load, wb_err;
  logic [63:0] wb_result, wb_mem_data;
  logic [4:0]  wb_rd;

  typedef struct {
    logic        is_load;
    logic [63:0] result;
    logic [63:0] mem_data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  mem_stage #(.XLEN(64), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_is_load(wb_is_load),
    .wb_result(wb_result), .wb_mem_data(wb_mem_data),
    .wb_rd(wb_rd), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: RISC-V access size, alignment and lane extraction.
  function automatic int unsigned size_b(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [63:0] addr);
    if (f3 == 3'b111) return 1'b1;
    return (addr % 64'(size_b(f3))) != 64'd0;
  endfunction

  function automatic logic [63:0] byte_mask(input int unsigned sz);
    if (sz == 8) return '1;
    return (64'd1 << (8 * sz)) - 64'd1;
  endfunction

  function automatic logic [63:0] load_value(input logic [63:0] rdata, input logic [2:0] f3,
                                             input logic [63:0] addr);
    int unsigned sz;
    int unsigned lane;
    logic [63:0] m;
    logic [63:0] v;
    sz   = size_b(f3);
    lane = 32'(addr % 64'd8);
    m    = byte_mask(sz);
    v    = (rdata >> (8 * lane)) & m;
    if (f3 < 3'b011 && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wb_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_wb_valid: got wb_valid=1 result=%h expected no output", wb_result);
      end else begin
        e = sb_q.pop_front();
        check("wb_is_load",  64'(wb_is_load), 64'(e.is_load));
        check("wb_result",   wb_result,       e.result);
        check("wb_mem_data", wb_mem_data,     e.mem_data);
        check("wb_rd",       64'(wb_rd),      64'(e.rd));
        check("wb_err",      64'(wb_err),     64'(e.err));
      end
    end
  end

  // One op through the stage; delay >= TIMEOUT means memory never acks.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] sdata,
                       input logic [4:0] rd, input logic [63:0] rdata,
                       input int unsigned delay);
    exp_t e;
    bit mem, mis, acked;
    int unsigned sz, lane;
    mem  = ld | st;
    mis  = mem && is_misaligned(f3, addr);
    sz   = size_b(f3);
    lane = 32'(addr % 64'd8);
    check("ex_ready", 64'(ex_ready), 64'd1);
    e.result   = addr;
    e.rd       = rd;
    e.is_load  = mem ? ld : 1'b0;
    e.mem_data = 64'd0;
    e.err      = 1'b0;
    if (mis || (mem && delay >= TIMEOUT)) e.err = 1'b1;
    else if (ld) e.mem_data = load_value(rdata, f3, addr);
    sb_q.push_back(e);

    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_result = addr; ex_store_data = sdata; ex_rd = rd;
    step();
    ex_valid = 1'b0;
    if (mem && !mis) begin
      check("dm_addr", dm_addr, addr & ~64'h7);
      check("dm_we", 64'(dm_we), 64'(st));
      if (st) begin
        check("dm_wdata", dm_wdata, sdata << (8 * lane));
        check("dm_wstrb", 64'(dm_wstrb), 64'(((32'd1 << sz) - 32'd1) << lane));
      end
      acked = 1'b0;
      for (int unsigned k = 0; k < TIMEOUT && !acked; k++) begin
        check("dm_req_held", 64'(dm_req), 64'd1);
        ex_valid    = 1'($urandom_range(0, 1));
        ex_is_load  = 1'($urandom_range(0, 1));
        ex_is_store = ~ex_is_load;
        ex_funct3   = 3'b011;
        ex_result   = {$urandom, $urandom} & ~64'h7;
        if (k == delay) begin
          dm_ack   = 1'b1;
          dm_rdata = rdata;
          acked    = 1'b1;
        end
        step();
        ex_valid = 1'b0;
        dm_ack   = 1'b0;
        dm_rdata = {$urandom, $urandom};
      end
      check("dm_req_drop", 64'(dm_req), 64'd0);
    end
    step();
    check("wb_latency", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    exp_t e;
    int unsigned r, p, dly, sz;
    bit ld, st;
    logic [2:0]  f3;
    logic [63:0] addr;

    rst_n = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = '0; ex_result = '0; ex_store_data = '0; ex_rd = '0;
    dm_ack = 1'b0; dm_rdata = '0;
    repeat (2) step();
    check("rst_dm_req",   64'(dm_req),   64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_result", wb_result,    64'd0);
    check("rst_dm_wstrb", 64'(dm_wstrb), 64'd0);
    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    step();

    do_op(0, 0, 3'b000, 64'd20, 64'd0, 5'd5, 64'd0, 0);
    do_op(1, 0, 3'b000, 64'h1003, 64'd0, 5'd1, 64'h0000_0000_8000_0000, 2);
    do_op(1, 0, 3'b101, 64'h1006, 64'd0, 5'd2, 64'hBEEF_0000_0000_0000, 1);
    do_op(1, 0, 3'b010, 64'h1006, 64'd0, 5'd3, 64'hBEEF_0000_0000_0000, 0);
    do_op(0, 1, 3'b001, 64'h2002, 64'h1234, 5'd4, 64'd0, 3);
    do_op(1, 0, 3'b011, 64'h3000, 64'd0, 5'd6, 64'h1122_3344_5566_7788, TIMEOUT);
    dm_ack = 1'b1; dm_rdata = 64'hdead;
    step();
    dm_ack = 1'b0;
    step();
    do_op(0, 0, 3'b000, 64'h77, 64'd0, 5'd7, 64'd0, 0);
    do_op(1, 0, 3'b011, 64'h3008, 64'd0, 5'd8, 64'h8000_0000_0000_0001, TIMEOUT - 1);
    do_op(1, 0, 3'b111, 64'h4000, 64'd0, 5'd9, 64'd0, 0);
    do_op(0, 1, 3'b111, 64'h4000, 64'd5, 5'd10, 64'd0, 0);

    // Back-to-back pass-through ops, one result per cycle.
    for (int i = 0; i < 4; i++) begin
      check("burst_ready", 64'(ex_ready), 64'd1);
      e.is_load = 1'b0; e.result = 64'(100 + i); e.mem_data = '0; e.rd = 5'(i + 11); e.err = 1'b0;
      sb_q.push_back(e);
      ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0;
      ex_result = 64'(100 + i); ex_rd = 5'(i + 11);
      step();
    end
    ex_valid = 1'b0;
    step();
    check("burst_drain", 64'(sb_q.size()), 64'd0);

    // Async reset in the middle of an access.
    do_op(0, 0, 3'b000, 64'd20, 64'd0, 5'd5, 64'd0, 0);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b011;
    ex_result = 64'h5008; ex_rd = 5'd12;
    step();
    ex_valid = 1'b0;
    check("rstmid_req_before", 64'(dm_req), 64'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_dm_req",   64'(dm_req),     64'd0);
    check("rstmid_wb_valid", 64'(wb_valid),   64'd0);
    check("rstmid_is_load",  64'(wb_is_load), 64'd0);
    check("rstmid_result",   wb_result,       64'd0);
    check("rstmid_mem_data", wb_mem_data,     64'd0);
    check("rstmid_rd",       64'(wb_rd),      64'd0);
    check("rstmid_err",      64'(wb_err),     64'd0);
    check("rstmid_ready",    64'(ex_ready),   64'd1);
    step();
    rst_n = 1'b1;
    dm_ack = 1'b1; dm_rdata = 64'hffff;
    step();
    dm_ack = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      ld = 1'b0; st = 1'b0;
      f3 = 3'($urandom_range(0, 6));
      if (r < 25) begin
        ld = 1'b0;
      end else if (r < 62) begin
        ld = 1'b1;
        if ($urandom_range(0, 19) == 0) f3 = 3'b111;
      end else begin
        st = 1'b1;
        f3 = 3'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) f3 = 3'b111;
      end
      addr = {$urandom, $urandom};
      sz = size_b(f3);
      if ($urandom_range(0, 9) < 7) addr = addr & ~64'(sz - 1);
      p = $urandom_range(0, 99);
      if (p < 2) dly = TIMEOUT;
      else if (p < 4) dly = TIMEOUT - 1;
      else dly = $urandom_range(0, 5);
      do_op(ld, st, f3, addr, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
            {$urandom, $urandom}, dly);
    end

    repeat (3) step();
    check("final_queue_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
